// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the ID-stage branch redirect controller:
// MIPS opcode/funct codes, FSM encoding and decode helpers.
package branch_redirect_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_TEQ     = 6'h34;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0004;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_OPND = 3'd1,
    S_EXC_SAVE  = 3'd2,
    S_EXC_JUMP  = 3'd3,
    S_ERET_JUMP = 3'd4
  } state_e;

  function automatic logic is_ctrl_flow(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return (op inside {OP_BEQ, OP_BNE, OP_REGIMM,
                       OP_J, OP_JAL}) ||
           (op == OP_SPECIAL &&
            (fn == FN_JR || fn == FN_JALR));
  endfunction

  // Register-sourced instructions; J/JAL never wait on operands.
  function automatic logic can_wait(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return (op inside {OP_BEQ, OP_BNE, OP_REGIMM}) ||
           (op == OP_SPECIAL &&
            (fn == FN_JR || fn == FN_JALR || fn == FN_TEQ));
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl.sv
// ID-stage branch/exception sequencer: operand-wait stalls,
// PC redirects, two-cycle exception entry and ERET return.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int          STALL_MAX  = 3
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        id_valid,
  input  logic [5:0]  id_opcode,
  input  logic [5:0]  id_funct,
  input  logic [31:0] id_pc,
  input  logic        operand_busy,
  input  logic        branch_decision,
  input  logic [31:0] branch_target,
  input  logic        exc_req,
  input  logic [4:0]  exc_cause,
  input  logic        eret_req,
  input  logic [31:0] cp0_epc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        epc_we,
  output logic [31:0] epc_out,
  output logic        cause_we,
  output logic [4:0]  cause_out,
  output logic        stall_fault,
  output logic        busy
);

  localparam int CW = $clog2(STALL_MAX + 1);

  state_e          st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [31:0]     epc_q, epc_d;
  logic [4:0]      cause_q, cause_d;
  logic            fault_q, fault_d;
  logic            act;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      fault_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      fault_q <= fault_d;
    end
  end

  assign cnt_inc     = cnt_q + CW'(1);
  assign epc_out     = epc_q;
  assign cause_out   = cause_q;
  assign stall_fault = fault_q;
  assign busy        = (st_q != S_IDLE);

  always_comb begin
    st_d           = st_q;
    cnt_d          = cnt_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    fault_d        = fault_q;
    act            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pc_stall       = 1'b0;
    ifid_stall     = 1'b0;
    idex_bubble    = 1'b0;
    ifid_flush     = 1'b0;
    epc_we         = 1'b0;
    cause_we       = 1'b0;
    unique case (st_q)
      S_IDLE, S_WAIT_OPND: begin
        // A waiting branch is still held in IF/ID.
        act = (st_q == S_WAIT_OPND) || id_valid;
        if (act) begin
          if (exc_req) begin
            st_d        = S_EXC_SAVE;
            cnt_d       = '0;
            epc_d       = id_pc;
            cause_d     = exc_cause;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (eret_req) begin
            st_d        = S_ERET_JUMP;
            cnt_d       = '0;
            idex_bubble = 1'b1;
          end else if (operand_busy &&
                       can_wait(id_opcode, id_funct)) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            if (st_q == S_IDLE) begin
              st_d  = S_WAIT_OPND;
              cnt_d = CW'(1);
            end else if (cnt_inc == CW'(STALL_MAX)) begin
              st_d    = S_IDLE;
              cnt_d   = '0;
              fault_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            st_d  = S_IDLE;
            cnt_d = '0;
            if (is_ctrl_flow(id_opcode, id_funct) &&
                branch_decision) begin
              redirect_valid = 1'b1;
              redirect_pc    = branch_target;
            end
          end
        end
      end
      S_EXC_SAVE: begin
        epc_we   = 1'b1;
        cause_we = 1'b1;
        pc_stall = 1'b1;
        st_d     = S_EXC_JUMP;
      end
      S_EXC_JUMP: begin
        redirect_valid = 1'b1;
        redirect_pc    = EXC_VECTOR;
        ifid_flush     = 1'b1;
        st_d           = S_IDLE;
      end
      S_ERET_JUMP: begin
        redirect_valid = 1'b1;
        redirect_pc    = cp0_epc;
        ifid_flush     = 1'b1;
        st_d           = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequencing controller around the ID-stage branch evaluator of the 5-stage MIPS pipeline. Decides when a branch/jump/trap decision is valid, stalls the front end while branch operands are still in flight, and issues one-cycle PC redirects. Runs the two-cycle exception entry (EPC/Cause write, then vector jump) and the ERET return. Sits between ID decode, the hazard unit, CP0 and the PC mux.

## Interface
Parameters:
- EXC_VECTOR, 32'h0000_0004, handler entry address
- STALL_MAX, 3, max consecutive operand-wait cycles before fatal flag

Ports:
- clk_in  in  1  pipeline clock
- reset_in  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  6  ID opcode (codes from mips_def.vh)
- id_funct  in  6  ID function field
- id_pc  in  32  PC of ID instruction
- operand_busy  in  1  a branch source register is still written by a load in EX/MEM
- branch_decision  in  1  evaluator taken result, valid when operand_busy=0
- branch_target  in  32  computed target (PC-rel, J-type or rs)
- exc_req  in  1  exception raised (syscall/break/TEQ trap)
- exc_cause  in  5  cause code with exc_req
- eret_req  in  1  ERET in ID
- cp0_epc  in  32  current EPC value
- redirect_valid  out  1  load redirect_pc into PC this cycle
- redirect_pc  out  32  next PC when redirect_valid
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- idex_bubble  out  1  insert NOP into ID/EX
- ifid_flush  out  1  clear IF/ID
- epc_we  out  1  write EPC
- epc_out  out  32  EPC value (id_pc)
- cause_we  out  1  write Cause
- cause_out  out  5  latched cause
- stall_fault  out  1  sticky: STALL_MAX exceeded
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WAIT_OPND, EXC_SAVE, EXC_JUMP, ERET_JUMP.
- Control-flow instr = BEQ, BNE, BGEZ, J, JAL, JR, JALR; trap-capable = TEQ.
- IDLE priority (single cycle, id_valid=1): exc_req > eret_req > control-flow.
  - exc_req: latch id_pc, exc_cause; -> EXC_SAVE; assert ifid_flush, idex_bubble.
  - eret_req: -> ERET_JUMP; assert idex_bubble.
  - control-flow with operand_busy=1 (BEQ/BNE/BGEZ/JR/JALR/TEQ only): -> WAIT_OPND; counter=1; pc_stall, ifid_stall, idex_bubble.
  - control-flow, operand_busy=0: if branch_decision=1, redirect_valid=1, redirect_pc=branch_target, same cycle; stay IDLE. Delay slot kept: no ifid_flush.
  - TEQ with operand_busy=0 and equal operands arrives as exc_req from decode; no special path here.
- WAIT_OPND: stall outputs held; operand_busy=0 -> resolve as IDLE same cycle, return IDLE. counter increments each busy cycle; counter==STALL_MAX -> set stall_fault, return IDLE, no redirect.
- EXC_SAVE: epc_we=1, cause_we=1, epc_out/cause_out = latched values; pc_stall=1; -> EXC_JUMP.
- EXC_JUMP: redirect_valid=1, redirect_pc=EXC_VECTOR, ifid_flush=1; -> IDLE.
- ERET_JUMP: redirect_valid=1, redirect_pc=cp0_epc, ifid_flush=1; -> IDLE.
- exc_req/eret_req outside IDLE/WAIT_OPND ignored; exc_req in WAIT_OPND aborts wait -> EXC_SAVE.
- id_valid=0 in IDLE: all outputs inactive.

## Timing
- Reset: state IDLE, counter 0, all outputs 0 incl. redirect_pc, epc_out, cause_out, stall_fault.
- Reset mid-sequence (any state) returns IDLE next edge; pending EPC/Cause writes dropped.
- Resolved branch: redirect combinational in decision cycle (0-cycle latency).
- Branch behind load: redirect in first cycle operand_busy=0.
- Exception: EPC/Cause write at +1, vector redirect at +2; busy high for 2 cycles.
- ERET: redirect at +1.
- Outputs combinational from state + inputs; state, counter, latches registered.

## Structure
- Opcode/funct codes from mips_def.vh; add state encoding (3-bit) and EXC_VECTOR default there.
- Single module; no sub-module. Optional helper function is_ctrl_flow(opcode,funct).

## Test plan
- BEQ id_pc=0x100, busy=0, decision=1, target=0x140 -> redirect_valid=1, redirect_pc=0x140 same cycle, ifid_flush=0.
- BNE with operand_busy high 2 cycles then decision=1 -> pc_stall/ifid_stall/idex_bubble for 2 cycles, redirect on 3rd, busy=1 during wait.
- operand_busy held 3 cycles (STALL_MAX=3) -> stall_fault=1 sticky, no redirect, returns IDLE.
- exc_req at id_pc=0x200, cause=8, simultaneous BEQ taken -> no branch redirect; cycle+1 epc_we, epc_out=0x200, cause_out=8; cycle+2 redirect_pc=0x4.
- eret_req with cp0_epc=0x204 -> cycle+1 redirect_pc=0x204, ifid_flush=1.
- reset_in asserted in EXC_SAVE -> next cycle IDLE, epc_we never seen at EXC_JUMP, all outputs 0.
